// File: rtl/mem_sync_arbiter.sv
// mem_sync_arbiter: shares one single-port synchronous RAM between two requesters
// with a registered round-robin owner FSM and a bounded burst length.
module mem_sync_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          gnt0_o,
    output logic          gnt1_o,
    output logic          rvalid0_o,
    output logic          rvalid1_o,
    output logic [DW-1:0] rdata0_o,
    output logic [DW-1:0] rdata1_o,
    output logic [AW-1:0] mem_address_o,
    output logic [DW-1:0] mem_wd_o,
    output logic          mem_wen_o,
    input  logic [DW-1:0] mem_rd_i
);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e        state_q, state_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rvalid0_q, rvalid1_q;
    logic          own1, req_own, req_oth;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= gnt0_o & ~we0_i;
            rvalid1_q <= gnt1_o & ~we1_i;
        end
    end

    assign own1    = (state_q == OWN1);
    assign req_own = own1 ? req1_i : req0_i;
    assign req_oth = own1 ? req0_i : req1_i;

    // Leaving an owner state always resets the burst and points rr_ptr away from the one just served.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        if (state_q == IDLE) begin
            state_d = (req0_i & req1_i) ? (rr_q ? OWN1 : OWN0) :
                      req0_i ? OWN0 : req1_i ? OWN1 : IDLE;
        end else if (req_own & ~(req_oth & (cnt_q == LAST))) begin
            cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        end else begin
            state_d = req_oth ? (own1 ? OWN0 : OWN1) : IDLE;
            cnt_d   = '0;
            rr_d    = ~own1;
        end
    end

    always_comb begin
        gnt0_o        = (state_q == OWN0) & req0_i;
        gnt1_o        = (state_q == OWN1) & req1_i;
        mem_wen_o     = (gnt0_o & we0_i) | (gnt1_o & we1_i);
        mem_address_o = own1 ? addr1_i : (state_q == OWN0) ? addr0_i : '0;
        mem_wd_o      = own1 ? wdata1_i : (state_q == OWN0) ? wdata0_i : '0;
    end

    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata0_o  = mem_rd_i;
    assign rdata1_o  = mem_rd_i;
endmodule

// File: tb/tb_mem_sync_arbiter.sv
// tb_mem_sync_arbiter: directed bench for mem_sync_arbiter with a behavioural mem_sync RAM
// whose unwritten words read back as {8'hA0, address}.
module tb_mem_sync_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1, mem_address;
    logic [15:0] wdata0, wdata1, rdata0, rdata1, mem_wd, mem_rd;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_wen;
    logic [1:0]  g;
    logic [15:0] ram [256];
    bit          wr_f [256];
    int          total = 0, bad = 0, wen_cnt = 0, rv1_cnt = 0;
    int          n0, n1, snap;
    logic [1:0]  t3_exp [21] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1,
                                 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd2};

    always #5 clk = ~clk;

    mem_sync_arbiter #(.AW(8), .DW(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .rdata0_o(rdata0), .rdata1_o(rdata1),
        .mem_address_o(mem_address), .mem_wd_o(mem_wd), .mem_wen_o(mem_wen), .mem_rd_i(mem_rd)
    );

    always @(posedge clk) begin
        if (mem_wen) begin
            ram[mem_address]  <= mem_wd;
            wr_f[mem_address] <= 1'b1;
        end
        mem_rd <= wr_f[mem_address] ? ram[mem_address] : {8'hA0, mem_address};
    end

    always @(negedge clk) begin
        if (mem_wen) wen_cnt++;
        if (rvalid1) rv1_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic wait_gnt(input bit p);
        int n = 0;
        while (!(p ? gnt1 : gnt0) && n < 8) begin
            tick();
            n++;
        end
        chk("gnt_wait", p ? gnt1 : gnt0, 1);
    endtask

    task automatic access(input bit p, input logic w, input logic [7:0] a, input logic [15:0] d, input logic [15:0] e);
        drive(p, 1'b1, w, a, d);
        #1;
        wait_gnt(p);
        chk("acc_addr", mem_address, a);
        chk("acc_wen", mem_wen, w);
        tick();
        drive(p, 1'b0, w, a, d);
        #1;
        chk("acc_rvalid", p ? rvalid1 : rvalid0, !w);
        if (!w) chk("acc_rdata", p ? rdata1 : rdata0, e);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_rv0", rvalid0, 0);
        chk("rst_rv1", rvalid1, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wd", mem_wd, 0);
        rst_n = 1'b1;
        tick();
        // write then read the same word; rvalid is a single-cycle pulse
        access(0, 1, 8'h11, 16'h0010, 16'h0);
        access(0, 0, 8'h11, 16'h0, 16'h0010);
        tick();
        chk("t1_rv_pulse", rvalid0, 0);
        // simultaneous first requests after reset: port 0 first, then port 1
        do_reset();
        drive(0, 1, 0, 8'h13, 0);
        drive(1, 1, 0, 8'h15, 0);
        #1;
        chk("t2_c0", {gnt1, gnt0}, 2'b00);
        tick();
        chk("t2_c1", {gnt1, gnt0}, 2'b01);
        chk("t2_addr0", mem_address, 8'h13);
        tick();
        drive(0, 0, 0, 8'h13, 0);
        #1;
        chk("t2_c2", {gnt1, gnt0}, 2'b00);
        chk("t2_rv0", rvalid0, 1);
        chk("t2_rd0", rdata0, 16'hA013);
        tick();
        chk("t2_c3", {gnt1, gnt0}, 2'b10);
        chk("t2_addr1", mem_address, 8'h15);
        chk("t2_rv0_off", rvalid0, 0);
        tick();
        drive(1, 0, 0, 8'h15, 0);
        #1;
        chk("t2_rv1", rvalid1, 1);
        chk("t2_rd1", rdata1, 16'hA015);
        tick();
        chk("t2_rv1_off", rvalid1, 0);
        // contention with bursts of four: port 0 issues 10 writes, port 1 writes continuously
        n0 = 0;
        n1 = 0;
        drive(0, 1, 1, 8'h20, 16'h0100);
        drive(1, 1, 1, 8'h40, 16'h0200);
        #1;
        for (int k = 0; k < 21; k++) begin
            if (k > 0) begin
                tick();
                if (g[0]) begin
                    n0++;
                    if (n0 == 10) req0 = 1'b0;
                    else begin
                        addr0 = 8'h20 + 8'(n0);
                        wdata0 = 16'h0100 + 16'(n0);
                    end
                end
                if (g[1]) begin
                    n1++;
                    addr1 = 8'h40 + 8'(n1);
                    wdata1 = 16'h0200 + 16'(n1);
                end
                #1;
            end
            g = {gnt1, gnt0};
            chk("t3_seq", g, t3_exp[k]);
        end
        tick();
        req1 = 1'b0;
        #1;
        access(0, 0, 8'h29, 16'h0, 16'h0109);
        access(1, 0, 8'h48, 16'h0, 16'h0208);
        access(1, 0, 8'h43, 16'h0, 16'h0203);
        // burst counter saturates while alone, so a late request is served after one more grant
        do_reset();
        drive(0, 1, 1, 8'h60, 16'h0300);
        #1;
        repeat (6) tick();
        drive(1, 1, 0, 8'h61, 0);
        #1;
        chk("sat_c6", {gnt1, gnt0}, 2'b01);
        tick();
        chk("sat_c7", {gnt1, gnt0}, 2'b10);
        tick();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();
        tick();
        // port 1 write then port 0 read of the same word; port 1 never sees rvalid
        snap = rv1_cnt;
        access(1, 1, 8'h17, 16'h0016, 16'h0);
        access(0, 0, 8'h17, 16'h0, 16'h0016);
        tick();
        chk("t4_rv1_cnt", rv1_cnt - snap, 0);
        // asynchronous reset in the middle of a write grant and of a read grant
        drive(1, 1, 1, 8'h30, 16'hBEEF);
        #1;
        wait_gnt(1);
        chk("t5_wen_pre", mem_wen, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_gnt1", gnt1, 0);
        chk("t5_wen", mem_wen, 0);
        chk("t5_addr", mem_address, 0);
        drive(1, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        drive(0, 1, 0, 8'h30, 0);
        #1;
        wait_gnt(0);
        #2 rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        chk("t5_rv0", rvalid0, 0);
        chk("t5_gnt0", gnt0, 0);
        rst_n = 1'b1;
        drive(0, 1, 0, 8'h30, 0);
        #1;
        chk("t5_idle", gnt0, 0);
        tick();
        chk("t5_regnt", gnt0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("t5_rv_after", rvalid0, 1);
        chk("t5_aborted_wr", rdata0, 16'hA030);
        // lone port 1 read; FSM returns to IDLE once req1 drops
        tick();
        tick();
        snap = wen_cnt;
        drive(1, 1, 0, 8'h15, 0);
        #1;
        chk("t6_c0", gnt1, 0);
        tick();
        chk("t6_c1", {gnt1, gnt0}, 2'b10);
        tick();
        drive(1, 0, 0, 8'h15, 0);
        #1;
        chk("t6_rv1", rvalid1, 1);
        chk("t6_rd1", rdata1, 16'hA015);
        tick();
        drive(1, 1, 0, 8'h15, 0);
        #1;
        chk("t6_idle", gnt1, 0);
        tick();
        chk("t6_regnt", gnt1, 1);
        tick();
        drive(1, 0, 0, 0, 0);
        #1;
        tick();
        chk("t6_wen_cnt", wen_cnt - snap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
